// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer: packs a valid/ready byte stream big-endian into 32-bit
// words for the keccak core's in/in_ready/is_last/byte_num interface.
// Generates the trailing zero word for word-aligned messages and then holds
// off new input until the core reports out_ready.
// Optional feature macro: SHA3_PACK_LEN_COUNT_EN adds the msg_bytes counter.
module sha3_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] in,
    output logic        in_ready,
    output logic        is_last,
    output logic [1:0]  byte_num,
    input  logic        buffer_full,
    input  logic        out_ready
`ifdef SHA3_PACK_LEN_COUNT_EN
    ,
    output logic [31:0] msg_bytes
`endif
);

    localparam logic [1:0] ST_ACCEPT = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [23:0] acc_reg, acc_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [31:0] word_reg, word_next;
    logic        valid_reg, valid_next;
    logic        last_reg, last_next;
    logic [1:0]  bn_reg, bn_next;

    logic        xfer;
    logic        accept;
    logic        leave_wait;
    logic [31:0] packed_word;
    logic [7:0]  lane_byte [4];

    // The pending word leaves on any edge the core is not full.
    assign xfer       = valid_reg && !buffer_full;
    // A byte may enter when the output register is free or is emptying now;
    // gated by reset_n so nothing is offered while reset is held.
    assign s_ready    = reset_n && (state_reg == ST_ACCEPT) && (!valid_reg || !buffer_full);
    assign accept     = s_valid && s_ready;
    // The digest only ends the message once the final word is gone.
    assign leave_wait = (state_reg == ST_WAIT) && !valid_reg && out_ready;

    // Byte lanes of the word that would be emitted if this byte closes it:
    // stored bytes, then the incoming byte, then zero padding.
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        if (gi < 3) begin : g_low
            assign lane_byte[gi] = (2'(gi) < cnt_reg)  ? acc_reg[23-8*gi -: 8] :
                                   (2'(gi) == cnt_reg) ? s_data : 8'h00;
        end else begin : g_top
            assign lane_byte[gi] = (cnt_reg == 2'd3) ? s_data : 8'h00;
        end
        assign packed_word[31-8*gi -: 8] = lane_byte[gi];
    end

    // Next-state logic for the packer FSM, accumulator and output word.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        bn_next    = bn_reg;

        case (state_reg)
            ST_ACCEPT: begin
                if (xfer) begin
                    valid_next = 1'b0;
                end
                if (accept) begin
                    if ((cnt_reg == 2'd3) || s_last) begin
                        word_next  = packed_word;
                        valid_next = 1'b1;
                        cnt_next   = 2'd0;
                        acc_next   = 24'h0;
                        if (cnt_reg == 2'd3) begin
                            // Full word; an aligned end still owes a zero word.
                            last_next  = 1'b0;
                            bn_next    = 2'd0;
                            state_next = s_last ? ST_FLUSH : ST_ACCEPT;
                        end else begin
                            last_next  = 1'b1;
                            bn_next    = cnt_reg + 2'd1;
                            state_next = ST_WAIT;
                        end
                    end else begin
                        case (cnt_reg)
                            2'd0:    acc_next[23:16] = s_data;
                            2'd1:    acc_next[15:8]  = s_data;
                            default: acc_next[7:0]   = s_data;
                        endcase
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end
            ST_FLUSH: begin
                // Load the empty terminating word as the aligned word leaves.
                if (!valid_reg || !buffer_full) begin
                    word_next  = 32'h0;
                    valid_next = 1'b1;
                    last_next  = 1'b1;
                    bn_next    = 2'd0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (xfer) begin
                    valid_next = 1'b0;
                end
                if (leave_wait) begin
                    state_next = ST_ACCEPT;
                    acc_next   = 24'h0;
                    cnt_next   = 2'd0;
                end
            end
            default: begin
                state_next = ST_ACCEPT;
            end
        endcase
    end

    // State registers; reset discards any partial and pending word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_ACCEPT;
            acc_reg   <= 24'h0;
            cnt_reg   <= 2'd0;
            word_reg  <= 32'h0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            bn_reg    <= 2'd0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            bn_reg    <= bn_next;
        end
    end

    assign in       = word_reg;
    assign in_ready = valid_reg;
    assign is_last  = last_reg;
    assign byte_num = bn_reg;

`ifdef SHA3_PACK_LEN_COUNT_EN
    logic [31:0] msg_bytes_reg;

    // Saturating count of bytes accepted in the current message.
    always_ff @(posedge clk) begin
        if (!reset_n || leave_wait) begin
            msg_bytes_reg <= 32'h0;
        end else if (accept && (msg_bytes_reg != 32'hFFFF_FFFF)) begin
            msg_bytes_reg <= msg_bytes_reg + 32'd1;
        end
    end

    assign msg_bytes = msg_bytes_reg;
`endif

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Testbench for sha3_byte_packer: directed message table, hand-written
// backpressure / WAIT / reset sequences, and randomized messages checked
// against a word-list model built from the message bytes.
// Define SHA3_PACK_LEN_COUNT_EN to also check msg_bytes.
module tb_sha3_byte_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] in_word;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic        out_ready;
`ifdef SHA3_PACK_LEN_COUNT_EN
    logic [31:0] msg_bytes;
`endif

    sha3_byte_packer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .in          (in_word),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .out_ready   (out_ready)
`ifdef SHA3_PACK_LEN_COUNT_EN
        ,
        .msg_bytes   (msg_bytes)
`endif
    );

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } word_t;

    typedef struct {
        string       text;
        int          n_words;
        logic [31:0] first_w;
        logic [31:0] last_w;
        logic [1:0]  last_bn;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit bf_rand  = 1'b0;
    bit bf_force = 1'b0;
    int bf_pct   = 0;

    logic [7:0] msg_q[$];
    word_t      exp_q[$];
    word_t      got_q[$];
    vec_t       vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // buffer_full is driven only here: random or forced by the test.
    initial begin
        buffer_full = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            buffer_full = bf_rand ? ($urandom_range(99, 0) < bf_pct) : bf_force;
        end
    end

    // Record each word the core takes (transfer happens at the next edge).
    always @(negedge clk) begin
        if (reset_n && in_ready && !buffer_full) begin
            got_q.push_back({in_word, is_last, byte_num});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string t, input int n, input logic [31:0] f,
                                input logic [31:0] l, input logic [1:0] b);
        vec_t v;
        v.text    = t;
        v.n_words = n;
        v.first_w = f;
        v.last_w  = l;
        v.last_bn = b;
        return v;
    endfunction

    task automatic set_msg(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Reference: chop bytes into groups of four, first byte most significant;
    // a short tail is zero-padded and final; an aligned message gets an
    // extra empty final word.
    task automatic build_expected();
        int n;
        int k;
        logic [31:0] w;
        exp_q.delete();
        n = msg_q.size();
        for (int i = 0; i < n; i += 4) begin
            k = (n - i < 4) ? (n - i) : 4;
            w = 32'h0;
            for (int j = 0; j < k; j++) w = w | (32'(msg_q[i+j]) << (24 - 8*j));
            if (k < 4) exp_q.push_back({w, 1'b1, 2'(k)});
            else       exp_q.push_back({w, 1'b0, 2'd0});
        end
        if (n % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
    endtask

    // Present one byte (after an optional idle gap) until it is accepted.
    // Entered and left at 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap_max);
        int gap;
        int guard;
        gap   = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        guard = 0;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("byte_accepted", guard < 500, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Drain the message, check WAIT behaviour, pulse out_ready, compare words.
    task automatic finish_msg(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while ((got_q.size() < exp_q.size() || in_ready) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drained"}, guard < 1000, 1);
        check({name, "_s_ready_wait"}, s_ready, 0);
`ifdef SHA3_PACK_LEN_COUNT_EN
        check({name, "_msg_bytes_wait"}, msg_bytes, msg_q.size());
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_s_ready_pre_out_ready"}, s_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, "_s_ready_after_out_ready"}, s_ready, 1);
`ifdef SHA3_PACK_LEN_COUNT_EN
        check({name, "_msg_bytes_cleared"}, msg_bytes, 0);
`endif
        check({name, "_word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_word%0d", name, i), got_q[i], exp_q[i]);
        $display("msg %s: %0d bytes, %0d words seen, %0d expected",
                 name, msg_q.size(), got_q.size(), exp_q.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int len;
        reset_n   = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = 8'h00;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in", in_word, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_is_last", is_last, 0);
        check("rst_byte_num", byte_num, 0);
        check("rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        // Directed message table, back-to-back bytes, no backpressure.
        vecs.push_back(mk("Hello, world!", 4, 32'h48656C6C, 32'h21000000, 2'd1));
        vecs.push_back(mk("Hello, world",  4, 32'h48656C6C, 32'h00000000, 2'd0));
        vecs.push_back(mk("a",             1, 32'h61000000, 32'h61000000, 2'd1));
        vecs.push_back(mk("dog.",          2, 32'h646F672E, 32'h00000000, 2'd0));
        vecs.push_back(mk("abcdefg",       2, 32'h61626364, 32'h65666700, 2'd3));
        vecs.push_back(mk("xy",            1, 32'h78790000, 32'h78790000, 2'd2));
        foreach (vecs[v]) begin
            set_msg(vecs[v].text);
            build_expected();
            got_q.delete();
            t0 = cyc;
            for (int i = 0; i < msg_q.size(); i++)
                send_byte(msg_q[i], i == msg_q.size() - 1, 0);
            check({vecs[v].text, "_byte_rate"}, cyc - t0, msg_q.size());
            finish_msg(vecs[v].text);
            check({vecs[v].text, "_n_words"}, got_q.size(), vecs[v].n_words);
            if (got_q.size() > 0) begin
                check({vecs[v].text, "_first"}, got_q[0].w, vecs[v].first_w);
                check({vecs[v].text, "_last_w"}, got_q[got_q.size()-1].w, vecs[v].last_w);
                check({vecs[v].text, "_last_flag"}, got_q[got_q.size()-1].last, 1);
                check({vecs[v].text, "_last_bn"}, got_q[got_q.size()-1].bn, vecs[v].last_bn);
            end
        end

        // Backpressure: hold buffer_full 5 cycles with "The " pending.
        set_msg("The quick");
        build_expected();
        got_q.delete();
        for (int i = 0; i < 4; i++) send_byte(msg_q[i], 1'b0, 0);
        bf_force = 1'b1;
        s_valid  = 1'b1;
        s_data   = msg_q[4];
        s_last   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_held", in_word, 32'h54686520);
            check("bp_in_ready", in_ready, 1);
            check("bp_s_ready", s_ready, 0);
            @(posedge clk);
            #1;
        end
        bf_force = 1'b0;
        @(negedge clk);
        check("bp_release_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 5; i < msg_q.size(); i++)
            send_byte(msg_q[i], i == msg_q.size() - 1, 0);
        finish_msg("The quick");

        // Single byte; early out_ready while the word is still held is ignored.
        set_msg("a");
        build_expected();
        got_q.delete();
        bf_force = 1'b1;
        send_byte(8'h61, 1'b1, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("one_in", in_word, 32'h61000000);
        check("one_is_last", is_last, 1);
        check("one_byte_num", byte_num, 1);
        check("one_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        bf_force  = 1'b0;
        @(negedge clk);
        check("one_still_pending", in_ready, 1);
        check("one_early_out_ready_ignored", s_ready, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("one_wait_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        finish_msg("a_hold");

        // Mid-message reset after 6 bytes, then a fresh message.
        set_msg("quick ");
        for (int i = 0; i < 6; i++) send_byte(msg_q[i], 1'b0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in", in_word, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_is_last", is_last, 0);
        check("mid_rst_byte_num", byte_num, 0);
        check("mid_rst_s_ready_after", s_ready, 1);
`ifdef SHA3_PACK_LEN_COUNT_EN
        check("mid_rst_msg_bytes", msg_bytes, 0);
`endif
        @(posedge clk);
        #1;
        set_msg("dog.");
        build_expected();
        got_q.delete();
        for (int i = 0; i < msg_q.size(); i++)
            send_byte(msg_q[i], i == msg_q.size() - 1, 0);
        finish_msg("dog_after_reset");

        // Random messages with random gaps and random backpressure.
        bf_rand = 1'b1;
        bf_pct  = 35;
        for (int m = 0; m < 25; m++) begin
            len = int'($urandom_range(16, 1));
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            build_expected();
            got_q.delete();
            for (int i = 0; i < len; i++)
                send_byte(msg_q[i], i == len - 1, 2);
            finish_msg($sformatf("rand%0d", m));
        end
        bf_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
